// File: rtl/dpram_port_arb_if.sv
// rtl/dpram_port_arb_if.sv - requester and RAM-port signal bundle for dpram_port_arb
//   slave  : arbiter side (takes requests and ram_q, drives acks, rdata and the RAM port)
//   master : requesters plus RAM model side
interface dpram_port_arb_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 14
);
    logic                 req0, req1, req2;
    logic                 we0, we1, we2;
    logic [ADDRWIDTH-1:0] addr0, addr1, addr2;
    logic [DATAWIDTH-1:0] wdata0, wdata1, wdata2;
    logic                 ack0, ack1, ack2;
    logic [DATAWIDTH-1:0] rdata;
    logic [ADDRWIDTH-1:0] ram_address;
    logic [DATAWIDTH-1:0] ram_data;
    logic                 ram_wren;
    logic [DATAWIDTH-1:0] ram_q;

    modport slave (
        input  req0, req1, req2, we0, we1, we2,
        input  addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_q,
        output ack0, ack1, ack2, rdata, ram_address, ram_data, ram_wren
    );

    modport master (
        output req0, req1, req2, we0, we1, we2,
        output addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_q,
        input  ack0, ack1, ack2, rdata, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/dpram_port_arb.sv
// rtl/dpram_port_arb.sv - three-requester arbiter for one synchronous dpram port
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : req/we/addr/wdata 0..2 in, ack 0..2 and rdata out,
//                  ram_address/ram_data/ram_wren to the dpram, ram_q from it
//   Requester 0 has fixed priority; 1 and 2 alternate round-robin.
//   Optional macro ROM_PROTECT_EN: writes below ROM_WORDS are acked but not written.
module dpram_port_arb #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 14,
    parameter int ROM_WORDS = 8192
) (
    input  logic              clock,
    input  logic              reset,
    dpram_port_arb_if.slave   bus
);

`ifdef ROM_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    // One extra bit so ROM_WORDS == 2**ADDRWIDTH still compares correctly.
    localparam logic [ADDRWIDTH:0] ROM_LIMIT = ROM_WORDS[ADDRWIDTH:0];

    logic [2:0]           inflight_q, inflight_d;
    logic [2:0]           ack_q, ack_d;
    logic [1:0]           tag_q, tag_d;
    logic                 last2_q, last2_d;
    logic [ADDRWIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATAWIDTH-1:0] ram_data_q, ram_data_d;
    logic                 ram_wren_q, ram_wren_d;

    logic [2:0]           elig, grant;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic                 sel_we, rom_hit;

    // A requester whose access is still in the pipeline is masked, which also
    // covers the edge where its ack is being registered.
    always_comb begin
        elig  = {bus.req2, bus.req1, bus.req0} & ~inflight_q;
        grant = 3'b000;
        if (elig[0])                    grant = 3'b001;
        else if (elig[1] && elig[2])    grant = last2_q ? 3'b010 : 3'b100;
        else if (elig[1])               grant = 3'b010;
        else if (elig[2])               grant = 3'b100;
    end

    always_comb begin
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        sel_we    = bus.we0;
        if (grant[1]) begin
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_we    = bus.we1;
        end else if (grant[2]) begin
            sel_addr  = bus.addr2;
            sel_wdata = bus.wdata2;
            sel_we    = bus.we2;
        end
        rom_hit = ({1'b0, sel_addr} < ROM_LIMIT);
    end

    always_comb begin
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        tag_d         = tag_q;
        last2_d       = last2_q;
        // Every access completes on the edge after issue, so the only access
        // in flight after any edge is the one granted at that edge.
        inflight_d    = grant;
        ack_d         = (inflight_q != 3'b000) ? (3'b001 << tag_q) : 3'b000;

        if (grant != 3'b000) begin
            ram_address_d = sel_addr;
            ram_data_d    = sel_wdata;
            ram_wren_d    = sel_we & ~(PROTECT & rom_hit);
            tag_d         = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
        end

        // Requester 0 grants leave the 1/2 alternation untouched.
        if (grant[1])      last2_d = 1'b0;
        else if (grant[2]) last2_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q    <= 3'b000;
            ack_q         <= 3'b000;
            tag_q         <= 2'd0;
            last2_q       <= 1'b1;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            ack_q         <= ack_d;
            tag_q         <= tag_d;
            last2_q       <= last2_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign bus.ack0        = ack_q[0];
    assign bus.ack1        = ack_q[1];
    assign bus.ack2        = ack_q[2];
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;
    // The dpram read is registered, so ram_q lines up with the ack cycle.
    assign bus.rdata       = bus.ram_q;

endmodule

// File: tb/tb_dpram_port_arb.sv
// tb/tb_dpram_port_arb.sv - self-checking bench for dpram_port_arb
module tb_dpram_port_arb;

`ifdef ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    localparam logic [13:0] A0 = 14'h0100;
    localparam logic [13:0] A1 = 14'h2005;
    localparam logic [13:0] A2 = 14'h3000;
    localparam logic [13:0] AT = 14'h3FFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    dpram_port_arb_if #(.DATAWIDTH(8), .ADDRWIDTH(14)) bus ();

    dpram_port_arb #(.DATAWIDTH(8), .ADDRWIDTH(14), .ROM_WORDS(8192)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural dpram: registered read, write on rising edge.
    logic [7:0]  mem [0:16383];
    logic [7:0]  q_r;
    logic        pre_en = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clock) begin
        if (pre_en)            mem[pre_addr] <= pre_data;
        else if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        q_r <= mem[bus.ram_address];
    end
    assign bus.ram_q = q_r;

    typedef struct packed {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [13:0] a1;
        logic [13:0] a2;
        logic [7:0]  wd;
        logic [2:0]  ack;
        logic        wren;
        logic [13:0] addr;
        logic        chk;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] we,
                                input logic [13:0] a1, input logic [7:0] wd,
                                input logic [2:0] ack, input logic wren,
                                input logic [13:0] addr, input logic chk,
                                input logic [7:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.a1 = a1; v.a2 = A2; v.wd = wd;
        v.ack = ack; v.wren = wren; v.addr = addr; v.chk = chk; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] acks();
        return {bus.ack2, bus.ack1, bus.ack0};
    endfunction

    task automatic set_req(input int n, input logic r, input logic we,
                           input logic [13:0] a, input logic [7:0] wd);
        case (n)
            0: begin bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
            1: begin bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
            default: begin bus.req2 = r; bus.we2 = we; bus.addr2 = a; bus.wdata2 = wd; end
        endcase
    endtask

    // Single access on requester n, held until its ack, with a bounded wait.
    task automatic access(input string name, input int n, input logic we,
                          input logic [13:0] a, input logic [7:0] wd,
                          input logic exp_wren, input logic chk, input logic [7:0] exp_rd);
        int   lat = 0;
        logic wren_seen = 1'b0;
        logic [7:0] rd = '0;
        set_req(n, 1'b1, we, a, wd);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.ram_wren) wren_seen = 1'b1;
            if (acks()[n]) begin
                lat = c;
                rd  = bus.rdata;
                break;
            end
        end
        set_req(n, 1'b0, 1'b0, a, wd);
        check({name, "_latency"}, lat, 2);
        check({name, "_wren"}, wren_seen, exp_wren);
        if (chk) check({name, "_rdata"}, rd, exp_rd);
        @(negedge clock);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.we2 = 0;
        bus.addr0 = A0; bus.addr1 = A1; bus.addr2 = A2;
        bus.wdata0 = 0; bus.wdata1 = 0; bus.wdata2 = 0;

        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b000, 0, 14'h0, 0, 8'h00));
        // single read on requester 1
        vecs.push_back(mk(3'b010, 3'b000, A1, 8'h00, 3'b000, 0, A1, 0, 8'h00));
        vecs.push_back(mk(3'b010, 3'b000, A1, 8'h00, 3'b010, 0, A1, 1, 8'h5A));
        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b000, 0, A1, 0, 8'h00));
        // requester 2 writes then reads back
        vecs.push_back(mk(3'b100, 3'b100, A1, 8'h3C, 3'b000, 1, A2, 0, 8'h00));
        vecs.push_back(mk(3'b100, 3'b100, A1, 8'h3C, 3'b100, 0, A2, 0, 8'h00));
        vecs.push_back(mk(3'b100, 3'b000, A1, 8'h00, 3'b000, 0, A2, 0, 8'h00));
        vecs.push_back(mk(3'b100, 3'b000, A1, 8'h00, 3'b100, 0, A2, 1, 8'h3C));
        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b000, 0, A2, 0, 8'h00));
        // all three at once: grants 0, 1, 2
        vecs.push_back(mk(3'b111, 3'b000, A1, 8'h00, 3'b000, 0, A0, 0, 8'h00));
        vecs.push_back(mk(3'b111, 3'b000, A1, 8'h00, 3'b001, 0, A1, 1, 8'h11));
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b010, 0, A2, 1, 8'h5A));
        vecs.push_back(mk(3'b100, 3'b000, A1, 8'h00, 3'b100, 0, A2, 1, 8'h3C));
        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b000, 0, A2, 0, 8'h00));
        // round-robin with req0 cutting in
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b000, 0, A1, 0, 8'h00));
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b010, 0, A2, 1, 8'h5A));
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b100, 0, A1, 1, 8'h3C));
        vecs.push_back(mk(3'b111, 3'b000, A1, 8'h00, 3'b010, 0, A0, 1, 8'h5A));
        vecs.push_back(mk(3'b111, 3'b000, A1, 8'h00, 3'b001, 0, A2, 1, 8'h11));
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b100, 0, A1, 1, 8'h3C));
        vecs.push_back(mk(3'b110, 3'b000, A1, 8'h00, 3'b010, 0, A2, 1, 8'h5A));
        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b100, 0, A2, 1, 8'h3C));
        vecs.push_back(mk(3'b000, 3'b000, A1, 8'h00, 3'b000, 0, A2, 0, 8'h00));
        // top address write and readback
        vecs.push_back(mk(3'b010, 3'b010, AT, 8'hA5, 3'b000, 1, AT, 0, 8'h00));
        vecs.push_back(mk(3'b010, 3'b010, AT, 8'hA5, 3'b010, 0, AT, 0, 8'h00));
        vecs.push_back(mk(3'b010, 3'b000, AT, 8'h00, 3'b000, 0, AT, 0, 8'h00));
        vecs.push_back(mk(3'b010, 3'b000, AT, 8'h00, 3'b010, 0, AT, 1, 8'hA5));
        vecs.push_back(mk(3'b000, 3'b000, AT, 8'h00, 3'b000, 0, AT, 0, 8'h00));

        // reset state, with preloads done while reset is held
        repeat (2) @(negedge clock);
        check("rst_ack", acks(), 0);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_addr", bus.ram_address, 0);
        check("rst_data", bus.ram_data, 0);
        pre_en = 1'b1;
        pre_addr = A1;       pre_data = 8'h5A; @(negedge clock);
        pre_addr = A0;       pre_data = 8'h11; @(negedge clock);
        pre_addr = 14'h0010; pre_data = 8'h42; @(negedge clock);
        pre_addr = 14'h2000; pre_data = 8'h00; @(negedge clock);
        pre_en = 1'b0;
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.req0 = vecs[i].req[0]; bus.req1 = vecs[i].req[1]; bus.req2 = vecs[i].req[2];
            bus.we0 = vecs[i].we[0];   bus.we1 = vecs[i].we[1];   bus.we2 = vecs[i].we[2];
            bus.addr1 = vecs[i].a1;    bus.addr2 = vecs[i].a2;
            bus.wdata0 = vecs[i].wd;   bus.wdata1 = vecs[i].wd;   bus.wdata2 = vecs[i].wd;
            @(negedge clock);
            check($sformatf("v%0d_ack", i), acks(), vecs[i].ack);
            check($sformatf("v%0d_wren", i), bus.ram_wren, vecs[i].wren);
            check($sformatf("v%0d_addr", i), bus.ram_address, vecs[i].addr);
            if (vecs[i].wren) check($sformatf("v%0d_data", i), bus.ram_data, vecs[i].wd);
            if (vecs[i].chk)  check($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].rd);
        end

        // reset one cycle after requester 1 is issued
        set_req(1, 1'b1, 1'b0, A1, 8'h00);
        @(negedge clock);
        check("mid_issue_addr", bus.ram_address, A1);
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, A1, 8'h00);
        #1;
        check("mid_rst_addr", bus.ram_address, 0);
        check("mid_rst_wren", bus.ram_wren, 0);
        check("mid_rst_data", bus.ram_data, 0);
        @(negedge clock);
        check("mid_rst_noack", acks(), 0);
        reset = 1'b0;
        set_req(1, 1'b1, 1'b0, A1, 8'h00);
        set_req(2, 1'b1, 1'b0, A2, 8'h00);
        @(negedge clock);
        check("post_rst_first_grant", bus.ram_address, A1);
        check("post_rst_ack_none", acks(), 0);
        @(negedge clock);
        check("post_rst_ack1", acks(), 3'b010);
        check("post_rst_rdata", bus.rdata, 8'h5A);
        check("post_rst_grant2", bus.ram_address, A2);
        set_req(1, 1'b0, 1'b0, A1, 8'h00);
        @(negedge clock);
        check("post_rst_ack2", acks(), 3'b100);
        set_req(2, 1'b0, 1'b0, A2, 8'h00);
        @(negedge clock);

        // write-protected region, then an unprotected write
        access("rom_wr", 2, 1'b1, 14'h0010, 8'hFF, ~PROT, 1'b0, 8'h00);
        access("rom_rd", 2, 1'b0, 14'h0010, 8'h00, 1'b0, 1'b1, PROT ? 8'h42 : 8'hFF);
        access("ram_wr", 1, 1'b1, 14'h2000, 8'hAB, 1'b1, 1'b0, 8'h00);
        access("ram_rd", 1, 1'b0, 14'h2000, 8'h00, 1'b0, 1'b1, 8'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_port_arb.md
Name: dpram_port_arb

Overview:
- Three-requester arbiter that shares one synchronous port of the dual-port video/system RAM (dpram, 1-cycle registered read).
- Requester 0 is the video fetcher and has fixed highest priority.
- Requesters 1 (CPU) and 2 (tape/ROM loader) share the remaining slots round-robin.
- One access is issued per cycle, pipelined; each requester gets a single-cycle ack pulse carrying read data.

Parameters:
- DATAWIDTH, 8, data width; must match the dpram instance.
- ADDRWIDTH, 14, address width; must match the dpram instance.
- ROM_WORDS, 8192, number of words from address 0 that are write-protected (used only with ROM_PROTECT_EN).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0/req1/req2  in  1 each  request; held high until the matching ack.
- we0/we1/we2  in  1 each  1 = write, 0 = read; stable while req high.
- addr0/addr1/addr2  in  ADDRWIDTH each  word address; stable while req high.
- wdata0/wdata1/wdata2  in  DATAWIDTH each  write data; stable while req high.
- ack0/ack1/ack2  out  1 each  one-cycle completion pulse.
- rdata  out  DATAWIDTH  read data; valid only in a cycle where a read's ack is high.
- ram_address  out  ADDRWIDTH  to dpram address port.
- ram_data  out  DATAWIDTH  to dpram data port.
- ram_wren  out  1  to dpram wren port.
- ram_q  in  DATAWIDTH  from dpram q port.

Behaviour:
- Reset (async) clears ram_address, ram_data, ram_wren, ack0-2, in-flight flags and grant tag to 0; round-robin pointer set so requester 1 wins the first 1-vs-2 tie.
- Pipeline, two stages:
  - Edge E0 (issue): arbiter samples eligible reqs, picks a winner, registers ram_address/ram_data/ram_wren from it, sets its in-flight flag and a 2-bit tag.
  - Edge E1 (complete): dpram latches/reads; arbiter registers ack[tag] = 1 and clears that in-flight flag.
  - rdata is ram_q passed through, valid in the cycle after E1.
- Latency: req sampled at E0 gives ack high for exactly one cycle after E1, i.e. 2 edges. Writes are committed at E1.
- Eligibility: reqN high and N not in flight.
  - A req still high at the edge where its ack is being registered is masked.
  - A req still high at the edge after ack is a new request.
- Priority:
  - req0 always wins when eligible.
  - Otherwise, among 1 and 2, the one not most recently granted wins. The pointer updates only on a grant to 1 or 2; req0 grants leave it unchanged.
- No eligible requester at an edge: ram_wren registered 0, ram_address/ram_data hold previous values, no tag issued.
- Throughput: one issue per cycle, with different requesters back-to-back. A single requester can get at most one access per 2 cycles.
- Simultaneous events: ack for one requester and issue for another occur on the same edge without conflict. Acks are one-hot; at most one is high per cycle.
- ram_wren is high for exactly one cycle per write and never during reads.
- Addresses at 2**ADDRWIDTH-1: no wrap logic; passed unchanged.
- Reset mid-operation: the in-flight access is discarded and no ack is issued. A write registered before reset may or may not reach RAM, so requesters reissue after reset.

Optional Feature:
- Macro: ROM_PROTECT_EN.
- Defined: a write with address < ROM_WORDS is issued with ram_wren = 0. It is still arbitrated and acked with normal latency, and RAM is unchanged.
- Undefined: all writes go through; ROM_WORDS is ignored.

Test Plan:
- Single read: after reset, preload dpram[0x2005]=0x5A; req1=1, we1=0, addr1=0x2005 -> ack1 one cycle, 2 edges later, rdata=0x5A; ram_wren stays 0.
- Write then read: req2 writes 0x3C to 0x3000; after ack2, req2 reads 0x3000 -> ram_wren high for exactly one cycle; read returns 0x3C.
- Priority: req0, req1, req2 all high on the same edge, each held until its ack -> grants in order 0, 1, 2 on consecutive edges; acks on the next consecutive cycles, one-hot.
- Round-robin: req1 and req2 held high continuously, req0 low -> grants alternate 1, 2, 1, 2; asserting req0 mid-stream takes the next slot without changing the 1/2 alternation.
- Reset mid-operation: assert reset the cycle after req1's issue edge -> no ack1; all outputs 0; first grant after release with req1 and req2 both high goes to req1.
- ROM protect (macro defined, ROM_WORDS=8192): write 0xFF to 0x0010 -> ack returned, ram_wren stays 0, readback unchanged. Write to 0x2000 -> RAM updated. Macro undefined -> the 0x0010 write updates RAM.
